// File: rtl/usb_pkg.sv
// Shared types for the USB-to-SD bulk transaction sequencer.
// Holds received/transmitted PID codes, default timing limits and FSM states.
package usb_pkg;

   typedef enum logic [1:0] {
      PID_NONE  = 2'b00,
      PID_IN    = 2'b01,
      PID_OUT   = 2'b10,
      PID_DATA0 = 2'b11
   } rx_pid_t;

   typedef enum logic [1:0] {
      TX_ACK   = 2'b00,
      TX_NACK  = 2'b01,
      TX_DATA0 = 2'b10
   } tx_pid_t;

   localparam int HS_TIMEOUT_DEF = 1024;
   localparam int MAX_RETRY_DEF  = 3;
   localparam int TMR_W_DEF      = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_OUT_WAIT,
      ST_SD_WR,
      ST_IN_LOAD,
      ST_ACK,
      ST_NACK,
      ST_DATA,
      ST_WAIT_HS,
      ST_FLUSH
   } state_t;

endpackage

// File: rtl/usb_hs_timer.sv
// Handshake timeout counter: saturating TMR_W-bit count with clear/enable.
// Ports: clk, n_rst, clear, enable in; expired out (count==HS_TIMEOUT-1 while enabled).
module usb_hs_timer #(
   parameter int TMR_W      = 16,
   parameter int HS_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(HS_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] SAT  = '1;

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && cnt != SAT)
         cnt <= cnt + TMR_W'(1);
   end

   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/usb_trans_sequencer.sv
// Bulk-path transaction sequencer: answers host tokens with ACK/NACK/DATA0,
// drives SD read/write requests, and retries DATA0 on missing host ACK.
// Inputs: clk, n_rst, pckt_valid, pckt_rcvd[1:0], send_nack, rcvd_exp_hs,
//   sd_data_ready, sd_write_done, tx_done.
// Outputs: tx_start, tx_pid[1:0], sd_read_req, sd_write_req, ack_packet_rcv,
//   dbuff_clr, busy, retry_cnt[1:0], xfer_err.
module usb_trans_sequencer
   import usb_pkg::*;
#(
   parameter int HS_TIMEOUT = HS_TIMEOUT_DEF,
   parameter int MAX_RETRY  = MAX_RETRY_DEF,
   parameter int TMR_W      = TMR_W_DEF
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       pckt_valid,
   input  logic [1:0] pckt_rcvd,
   input  logic       send_nack,
   input  logic       rcvd_exp_hs,
   input  logic       sd_data_ready,
   input  logic       sd_write_done,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [1:0] tx_pid,
   output logic       sd_read_req,
   output logic       sd_write_req,
   output logic       ack_packet_rcv,
   output logic       dbuff_clr,
   output logic       busy,
   output logic [1:0] retry_cnt,
   output logic       xfer_err
);

   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

   state_t     state;
   logic       tx_first;
   logic [1:0] retry_q;
   logic       err_q;
   logic       ack_q;
   logic       tmr_en;
   logic       tmr_exp;
   logic       tx_ok;

   // Held at zero outside the two waiting states, so each wait starts at 0.
   assign tmr_en = (state == ST_OUT_WAIT) || (state == ST_WAIT_HS);

   usb_hs_timer #(
      .TMR_W      (TMR_W),
      .HS_TIMEOUT (HS_TIMEOUT)
   ) u_tmr (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (!tmr_en),
      .enable  (tmr_en),
      .expired (tmr_exp)
   );

   // A tx_done seen in the same cycle as tx_start belongs to an older packet.
   assign tx_ok = tx_done && !tx_first;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         tx_first <= 1'b0;
         retry_q  <= 2'd0;
         err_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         ack_q    <= pckt_valid;
         tx_first <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (send_nack) begin
                  state    <= ST_NACK;
                  tx_first <= 1'b1;
               end else if (pckt_valid) begin
                  unique case (rx_pid_t'(pckt_rcvd))
                     PID_IN: begin
                        state   <= ST_IN_LOAD;
                        err_q   <= 1'b0;
                        retry_q <= 2'd0;
                     end
                     PID_OUT: begin
                        state <= ST_OUT_WAIT;
                        err_q <= 1'b0;
                     end
                     PID_DATA0: begin
                        state    <= ST_NACK;
                        tx_first <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_OUT_WAIT: begin
               if (send_nack ||
                   (pckt_valid && pckt_rcvd != PID_DATA0)) begin
                  state    <= ST_NACK;
                  tx_first <= 1'b1;
               end else if (pckt_valid) begin
                  state <= ST_SD_WR;
               end else if (tmr_exp) begin
                  state <= ST_IDLE;
                  err_q <= 1'b1;
               end
            end
            ST_SD_WR: begin
               if (sd_write_done) begin
                  state    <= ST_ACK;
                  tx_first <= 1'b1;
               end
            end
            ST_IN_LOAD: begin
               if (sd_data_ready) begin
                  state    <= ST_DATA;
                  tx_first <= 1'b1;
               end
            end
            ST_ACK:  if (tx_ok) state <= ST_IDLE;
            ST_NACK: if (tx_ok) state <= ST_FLUSH;
            ST_DATA: if (tx_ok) state <= ST_WAIT_HS;
            ST_WAIT_HS: begin
               if (rcvd_exp_hs) begin
                  state   <= ST_FLUSH;
                  retry_q <= 2'd0;
               end else if (tmr_exp || send_nack) begin
                  if (retry_q < RETRY_MAX) begin
                     state    <= ST_DATA;
                     tx_first <= 1'b1;
                     retry_q  <= retry_q + 2'd1;
                  end else begin
                     state <= ST_FLUSH;
                     err_q <= 1'b1;
                  end
               end
            end
            ST_FLUSH: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_pid = TX_ACK;
      unique case (state)
         ST_NACK: tx_pid = TX_NACK;
         ST_DATA: tx_pid = TX_DATA0;
         default: tx_pid = TX_ACK;
      endcase
   end

   assign tx_start       = tx_first;
   assign sd_read_req    = (state == ST_IN_LOAD);
   assign sd_write_req   = (state == ST_SD_WR);
   assign dbuff_clr      = (state == ST_FLUSH);
   assign busy           = (state != ST_IDLE);
   assign ack_packet_rcv = ack_q;
   assign retry_cnt      = retry_q;
   assign xfer_err       = err_q;

endmodule

// File: tb/tb_usb_trans_sequencer.sv
// Self-checking bench for usb_trans_sequencer: reference model plus
// directed transaction scenarios with literal expectations.
module tb_usb_trans_sequencer;

   localparam int HS_T  = 16;
   localparam int MAXR  = 3;
   localparam int M_PV  = 1;
   localparam int M_NK  = 2;
   localparam int M_HS  = 4;
   localparam int M_RDY = 8;
   localparam int M_WD  = 16;
   localparam int M_TXD = 32;

   logic       clk = 0;
   logic       n_rst = 0;
   logic       pckt_valid = 0;
   logic [1:0] pckt_rcvd = 0;
   logic       send_nack = 0;
   logic       rcvd_exp_hs = 0;
   logic       sd_data_ready = 0;
   logic       sd_write_done = 0;
   logic       tx_done = 0;
   logic       tx_start;
   logic [1:0] tx_pid;
   logic       sd_read_req;
   logic       sd_write_req;
   logic       ack_packet_rcv;
   logic       dbuff_clr;
   logic       busy;
   logic [1:0] retry_cnt;
   logic       xfer_err;

   usb_trans_sequencer #(
      .HS_TIMEOUT (HS_T),
      .MAX_RETRY  (MAXR),
      .TMR_W      (16)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .pckt_valid     (pckt_valid),
      .pckt_rcvd      (pckt_rcvd),
      .send_nack      (send_nack),
      .rcvd_exp_hs    (rcvd_exp_hs),
      .sd_data_ready  (sd_data_ready),
      .sd_write_done  (sd_write_done),
      .tx_done        (tx_done),
      .tx_start       (tx_start),
      .tx_pid         (tx_pid),
      .sd_read_req    (sd_read_req),
      .sd_write_req   (sd_write_req),
      .ack_packet_rcv (ack_packet_rcv),
      .dbuff_clr      (dbuff_clr),
      .busy           (busy),
      .retry_cnt      (retry_cnt),
      .xfer_err       (xfer_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: transaction phase plus cycles spent in that phase.
   typedef enum int {
      M_IDLE, M_OWAIT, M_WR, M_LOAD, M_SACK, M_SNACK, M_SDATA, M_HSW, M_FLUSH
   } mst_t;

   mst_t ms = M_IDLE;
   mst_t nx;
   int   age = 0;
   int   mretry = 0;
   bit   merr = 0;
   bit   mack = 0;
   bit   mtmo;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ms = M_IDLE; age = 0; mretry = 0; merr = 0; mack = 0;
      end else begin
         mtmo = (age == HS_T - 1);
         mack = pckt_valid;
         nx = ms;
         case (ms)
            M_IDLE:
               if (send_nack) nx = M_SNACK;
               else if (pckt_valid) begin
                  if (pckt_rcvd == 2'd1) begin
                     nx = M_LOAD; merr = 0; mretry = 0;
                  end else if (pckt_rcvd == 2'd2) begin
                     nx = M_OWAIT; merr = 0;
                  end else if (pckt_rcvd == 2'd3) nx = M_SNACK;
               end
            M_OWAIT:
               if (send_nack) nx = M_SNACK;
               else if (pckt_valid)
                  nx = (pckt_rcvd == 2'd3) ? M_WR : M_SNACK;
               else if (mtmo) begin
                  nx = M_IDLE; merr = 1;
               end
            M_WR:   if (sd_write_done) nx = M_SACK;
            M_LOAD: if (sd_data_ready) nx = M_SDATA;
            M_SACK:  if (tx_done && age > 0) nx = M_IDLE;
            M_SNACK: if (tx_done && age > 0) nx = M_FLUSH;
            M_SDATA: if (tx_done && age > 0) nx = M_HSW;
            M_HSW:
               if (rcvd_exp_hs) begin
                  nx = M_FLUSH; mretry = 0;
               end else if (mtmo || send_nack) begin
                  if (mretry < MAXR) begin
                     nx = M_SDATA; mretry++;
                  end else begin
                     nx = M_FLUSH; merr = 1;
                  end
               end
            M_FLUSH: nx = M_IDLE;
            default: nx = M_IDLE;
         endcase
         age = (nx == ms) ? age + 1 : 0;
         ms = nx;
      end
   end

   function automatic bit m_sending();
      return ms == M_SACK || ms == M_SNACK || ms == M_SDATA;
   endfunction

   function automatic int m_pid();
      return (ms == M_SNACK) ? 1 : (ms == M_SDATA) ? 2 : 0;
   endfunction

   always @(negedge clk) begin
      if (chk_on && n_rst) begin
         chk("cyc_busy", busy, ms != M_IDLE);
         chk("cyc_sd_wr", sd_write_req, ms == M_WR);
         chk("cyc_sd_rd", sd_read_req, ms == M_LOAD);
         chk("cyc_clr", dbuff_clr, ms == M_FLUSH);
         chk("cyc_txs", tx_start, m_sending() && age == 0);
         chk("cyc_ackrx", ack_packet_rcv, mack);
         chk("cyc_retry", retry_cnt, mretry);
         chk("cyc_err", xfer_err, merr);
         if (m_sending()) chk("cyc_pid", tx_pid, m_pid());
      end
   end

   int         n_txs, n_data, n_ack, n_wr, n_clr;
   logic [1:0] last_pid;

   always @(negedge clk) begin
      if (n_rst) begin
         if (tx_start) begin
            n_txs++;
            last_pid = tx_pid;
            if (tx_pid == 2'd2) n_data++;
         end
         if (ack_packet_rcv) n_ack++;
         if (sd_write_req) n_wr++;
         if (dbuff_clr) n_clr++;
      end
   end

   task automatic clr_cnt();
      @(negedge clk);
      #1;
      n_txs = 0; n_data = 0; n_ack = 0; n_wr = 0; n_clr = 0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic [1:0] c);
      @(negedge clk);
      pckt_valid    = m[0];
      send_nack     = m[1];
      rcvd_exp_hs   = m[2];
      sd_data_ready = m[3];
      sd_write_done = m[4];
      tx_done       = m[5];
      pckt_rcvd     = c;
      @(negedge clk);
      pckt_valid = 0; send_nack = 0; rcvd_exp_hs = 0;
      sd_data_ready = 0; sd_write_done = 0; tx_done = 0;
      pckt_rcvd = 0;
   endtask

   task automatic serve_tx(input bit early);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx_start === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      n_chk++;
      if (!seen) begin
         n_err++;
         $display("FAIL tx_start_wait: got none want pulse in 40 cycles");
      end else begin
         if (early) begin
            tx_done = 1;
            @(negedge clk);
            tx_done = 0;
            chk("early_done_ignored", {busy, dbuff_clr}, 2'b10);
         end
         drive(M_TXD, 2'd0);
      end
   endtask

   function automatic logic [10:0] all_outs();
      return {tx_start, tx_pid, sd_read_req, sd_write_req, ack_packet_rcv,
              dbuff_clr, busy, retry_cnt, xfer_err};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      #2 n_rst = 0;
      #1 chk("rst_async_outs", all_outs(), 0);
      @(negedge clk);
      n_rst = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state_outs", all_outs(), 0);
      n_rst = 1;
      chk_on = 1;

      // OUT token, DATA0 10 cycles later, write done 5 cycles after that
      clr_cnt();
      drive(M_PV, 2'd2);
      repeat (8) @(negedge clk);
      drive(M_PV, 2'd3);
      repeat (3) @(negedge clk);
      drive(M_WD, 2'd0);
      serve_tx(0);
      settle(3);
      chk("s1_ack_pulses", n_ack, 2);
      chk("s1_wr_cycles", n_wr, 5);
      chk("s1_tx_count", n_txs, 1);
      chk("s1_tx_pid", last_pid, 0);
      chk("s1_busy", busy, 0);
      chk("s1_err", xfer_err, 0);

      // IN token, data after 8 cycles, host ACK 10 cycles after DATA0
      clr_cnt();
      drive(M_PV, 2'd1);
      repeat (6) @(negedge clk);
      drive(M_RDY, 2'd0);
      serve_tx(0);
      repeat (8) @(negedge clk);
      drive(M_HS, 2'd0);
      settle(3);
      chk("s2_data_count", n_data, 1);
      chk("s2_clr_pulses", n_clr, 1);
      chk("s2_retry", retry_cnt, 0);
      chk("s2_busy", busy, 0);

      // IN token, host never ACKs; first retry forced by a receive error
      clr_cnt();
      drive(M_PV, 2'd1);
      drive(M_RDY, 2'd0);
      serve_tx(0);
      drive(M_NK, 2'd0);
      for (int k = 0; k < 3; k++) serve_tx(0);
      settle(20);
      chk("s3_data_count", n_data, 4);
      chk("s3_clr_pulses", n_clr, 1);
      chk("s3_retry", retry_cnt, 3);
      chk("s3_err", xfer_err, 1);
      chk("s3_busy", busy, 0);
      drive(M_PV, 2'd1);
      #1;
      chk("s3_err_cleared", xfer_err, 0);
      chk("s3_retry_cleared", retry_cnt, 0);
      drive(M_RDY, 2'd0);
      serve_tx(0);
      drive(M_HS, 2'd0);
      settle(3);

      // send_nack and OUT token together in IDLE; early tx_done ignored
      clr_cnt();
      drive(M_PV | M_NK, 2'd2);
      serve_tx(1);
      settle(3);
      chk("s4_tx_count", n_txs, 1);
      chk("s4_tx_pid", last_pid, 1);
      chk("s4_clr_pulses", n_clr, 1);
      chk("s4_ack_pulses", n_ack, 1);
      chk("s4_busy", busy, 0);

      // OUT token with no DATA0
      clr_cnt();
      drive(M_PV, 2'd2);
      settle(20);
      chk("s5_busy", busy, 0);
      chk("s5_err", xfer_err, 1);
      chk("s5_tx_count", n_txs, 0);

      // DATA0 with no token
      clr_cnt();
      drive(M_PV, 2'd3);
      serve_tx(0);
      settle(3);
      chk("s5b_tx_pid", last_pid, 1);
      chk("s5b_clr_pulses", n_clr, 1);
      chk("s5b_err_kept", xfer_err, 1);

      // reset during SD_WR, with a stray token ignored there
      drive(M_PV, 2'd2);
      drive(M_PV, 2'd3);
      drive(M_PV, 2'd1);
      settle(1);
      chk("s6_wr_active", sd_write_req, 1);
      do_reset();
      settle(1);
      chk("s6_busy_after", busy, 0);

      // reset during WAIT_HS after one retransmission
      drive(M_PV, 2'd1);
      drive(M_RDY, 2'd0);
      serve_tx(0);
      serve_tx(0);
      settle(1);
      chk("s6_retry_before", retry_cnt, 1);
      do_reset();
      settle(1);
      chk("s6_retry_after", retry_cnt, 0);
      chk("s6_busy_after2", busy, 0);
      chk("s6_err_after", xfer_err, 0);

      settle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
